// File: rtl/stp_key_pkg.sv
// -----------------------------------------------------------------------------
// stp_key_pkg
// Shared widths, types and helpers for the serial-to-parallel key collector.
//   BLOCK_BYTES / BYTE_W / BLOCK_W : geometry of one 128-bit block
//   ROUND_W                        : width of the round index
//   byte_slot(k)                   : MSB bit position of byte k inside a block
// -----------------------------------------------------------------------------
package stp_key_pkg;

  localparam int BLOCK_BYTES = 16;
  localparam int BYTE_W      = 8;
  localparam int BLOCK_W     = 128;
  localparam int ROUND_W     = 4;
  localparam int CNT_W       = 4;

  typedef logic [CNT_W-1:0]   byte_cnt_t;
  typedef logic [ROUND_W-1:0] round_t;

  // Byte 0 lands in the top byte of the block, byte 15 in the bottom byte.
  function automatic logic [6:0] byte_slot(input byte_cnt_t k);
    return 7'(BLOCK_W - 1) - {k, 3'b000};
  endfunction

endpackage

// File: rtl/stp_key_if.sv
// -----------------------------------------------------------------------------
// stp_key_if
// Byte-in / block-out bus of the key collector.
//   in_valid, in_byte, in_first : serial byte stream from the key serializer
//   in_ready                    : collector back-pressure to the byte source
//   out_valid, out_ready        : block handshake to the downstream consumer
//   out_block, out_round        : assembled 128-bit block and its round index
//   err                         : sticky protocol error flag
// Modports: slave = collector side, master = source/consumer side.
// -----------------------------------------------------------------------------
interface stp_key_if;
  import stp_key_pkg::*;

  logic               in_valid;
  logic [BYTE_W-1:0]  in_byte;
  logic               in_first;
  logic               in_ready;
  logic               out_valid;
  logic               out_ready;
  logic [BLOCK_W-1:0] out_block;
  round_t             out_round;
  logic               err;

  modport slave (
    input  in_valid, in_byte, in_first, out_ready,
    output in_ready, out_valid, out_block, out_round, err
  );

  modport master (
    output in_valid, in_byte, in_first, out_ready,
    input  in_ready, out_valid, out_block, out_round, err
  );

endinterface

// File: rtl/stp_key_outreg.sv
// -----------------------------------------------------------------------------
// stp_key_outreg
// Output holding register (128-bit block + 4-bit round) with valid/ready.
//   clk, rst  : clock, asynchronous active-high reset
//   i_load    : a completed block is presented this cycle
//   i_block   : completed block value
//   i_round   : round index of the completed block
//   i_ready   : downstream accepts the held block
//   o_valid   : held block is valid
//   o_block   : held block
//   o_round   : held round index
// A load in the same edge as an accept replaces the held block and keeps
// o_valid high, so back-to-back blocks stream without a bubble. The parent
// never loads while a block is held and not being accepted.
// -----------------------------------------------------------------------------
module stp_key_outreg
  import stp_key_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic [BLOCK_W-1:0] i_block,
  input  round_t             i_round,
  input  logic               i_ready,
  output logic               o_valid,
  output logic [BLOCK_W-1:0] o_block,
  output round_t             o_round
);

  logic               r_valid;
  logic [BLOCK_W-1:0] r_block;
  round_t             r_round;

  // Load wins over accept; data only changes on a load so it stays stable
  // while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_block <= '0;
      r_round <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_block <= i_block;
      r_round <= i_round;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_block = r_block;
  assign o_round = r_round;

endmodule

// File: rtl/stp_key.sv
// -----------------------------------------------------------------------------
// stp_key
// Serial-to-parallel round-key collector: gathers 16 bytes (MSB first) into a
// 128-bit block, tags it with a wrapping round index and hands it downstream.
//   clk, rst : clock, asynchronous active-high reset
//   io_bus   : stp_key_if.slave (byte input, block output, err)
// Parameters:
//   NUM_BLOCKS : blocks per key schedule, round index wraps at NUM_BLOCKS-1
//   TIMEOUT    : idle cycles before a partial block is dropped (only present
//                when STP_KEY_TIMEOUT_EN is defined)
// Optional feature macro: STP_KEY_TIMEOUT_EN enables the partial-block
// idle timeout; without it a partial block waits indefinitely.
// -----------------------------------------------------------------------------
module stp_key
  import stp_key_pkg::*;
#(
  parameter int NUM_BLOCKS = 11
`ifdef STP_KEY_TIMEOUT_EN
  ,
  parameter int TIMEOUT    = 32
`endif
) (
  input  logic      clk,
  input  logic      rst,
  stp_key_if.slave  io_bus
);

  localparam round_t ROUND_LAST = ROUND_W'(NUM_BLOCKS - 1);
  localparam byte_cnt_t CNT_LAST = byte_cnt_t'(BLOCK_BYTES - 1);

  byte_cnt_t          r_byteCnt;
  round_t             r_round;
  logic [BLOCK_W-1:0] r_collect;
  logic               r_err;

  logic               w_inReady;
  logic               w_accept;
  logic               w_complete;
  logic               w_timeout;
  logic [BLOCK_W-1:0] w_block;
  logic               w_outValid;
  logic [BLOCK_W-1:0] w_outBlock;
  round_t             w_outRound;

  // Only the final byte can be refused: it would need the output register,
  // which is still holding an unaccepted block.
  assign w_inReady  = !((r_byteCnt == CNT_LAST) && w_outValid && !io_bus.out_ready);
  assign w_accept   = io_bus.in_valid && w_inReady;
  // in_first restarts the block, so it never completes one even at count 15.
  assign w_complete = w_accept && !io_bus.in_first && (r_byteCnt == CNT_LAST);
  assign w_block    = {r_collect[BLOCK_W-1:BYTE_W], io_bus.in_byte};

`ifdef STP_KEY_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  logic [IDLE_W-1:0] r_idle;
  logic              w_idleCycle;

  // Idle time is counted only while a partial block exists and the
  // collector is actually willing to take a byte.
  assign w_idleCycle = (r_byteCnt != '0) && !w_accept && w_inReady;
  assign w_timeout   = w_idleCycle && (r_idle == IDLE_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idle <= '0;
    end else if (w_accept || (r_byteCnt == '0) || w_timeout) begin
      r_idle <= '0;
    end else if (w_inReady) begin
      r_idle <= r_idle + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Byte counter, collect register, round counter and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byteCnt <= '0;
      r_round   <= '0;
      r_collect <= '0;
      r_err     <= 1'b0;
    end else begin
      if (io_bus.in_valid && !w_inReady) begin
        r_err <= 1'b1;
      end
      if (w_accept) begin
        if (io_bus.in_first) begin
          r_collect[BLOCK_W-1 -: BYTE_W] <= io_bus.in_byte;
          r_byteCnt <= byte_cnt_t'(1);
          if (r_byteCnt != '0) begin
            r_err <= 1'b1;
          end
        end else begin
          r_collect[byte_slot(r_byteCnt) -: BYTE_W] <= io_bus.in_byte;
          // 4-bit counter wraps 15 -> 0 on block completion.
          r_byteCnt <= r_byteCnt + 1'b1;
          if (r_byteCnt == CNT_LAST) begin
            r_round <= (r_round == ROUND_LAST) ? '0 : r_round + 1'b1;
          end
        end
      end else if (w_timeout) begin
        r_byteCnt <= '0;
        r_err     <= 1'b1;
      end
    end
  end

  stp_key_outreg u_outreg (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_complete),
    .i_block (w_block),
    .i_round (r_round),
    .i_ready (io_bus.out_ready),
    .o_valid (w_outValid),
    .o_block (w_outBlock),
    .o_round (w_outRound)
  );

  assign io_bus.in_ready  = w_inReady;
  assign io_bus.out_valid = w_outValid;
  assign io_bus.out_block = w_outBlock;
  assign io_bus.out_round = w_outRound;
  assign io_bus.err       = r_err;

endmodule

// File: tb/tb_stp_key.sv
// -----------------------------------------------------------------------------
// tb_stp_key
// Self-checking bench for stp_key. A queue-based model of the collector is
// advanced once per cycle and compared against the DUT on every falling edge;
// directed sequences add literal expectations. Honours STP_KEY_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_stp_key;
  import stp_key_pkg::*;

  localparam int NUM_BLOCKS = 11;
  localparam int TIMEOUT    = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int assertCount = 0;
  int failCount   = 0;

  stp_key_if bus ();

  stp_key #(.NUM_BLOCKS(NUM_BLOCKS)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model state: bytes gathered so far, plus the output slot.
  logic [7:0]   mdlBytes[$];
  int           mdlRound;
  bit           mdlOutValid;
  logic [127:0] mdlOutBlock;
  int           mdlOutRound;
  bit           mdlErr;
  int           mdlIdle;

  task automatic checkVal(input string name, input logic [127:0] act, input logic [127:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit expReady();
    return !((mdlBytes.size() == 15) && mdlOutValid && !bus.out_ready);
  endfunction

  task automatic resetModel();
    mdlBytes.delete();
    mdlRound    = 0;
    mdlOutValid = 0;
    mdlOutBlock = '0;
    mdlOutRound = 0;
    mdlErr      = 0;
    mdlIdle     = 0;
  endtask

  // Apply the inputs currently on the bus as the next rising edge would.
  task automatic advanceModel();
    bit rdy;
    bit acc;
    logic [127:0] blk;
    rdy = expReady();
    acc = bus.in_valid && rdy;
    if (bus.in_valid && !rdy) mdlErr = 1;
    if (mdlOutValid && bus.out_ready) mdlOutValid = 0;
    if (acc) begin
      mdlIdle = 0;
      if (bus.in_first) begin
        if (mdlBytes.size() != 0) mdlErr = 1;
        mdlBytes.delete();
        mdlBytes.push_back(bus.in_byte);
      end else begin
        mdlBytes.push_back(bus.in_byte);
        if (mdlBytes.size() == 16) begin
          blk = '0;
          foreach (mdlBytes[i]) blk = {blk[119:0], mdlBytes[i]};
          mdlOutBlock = blk;
          mdlOutValid = 1;
          mdlOutRound = mdlRound;
          mdlRound    = (mdlRound + 1) % NUM_BLOCKS;
          mdlBytes.delete();
        end
      end
    end
`ifdef STP_KEY_TIMEOUT_EN
    else if (mdlBytes.size() != 0 && rdy) begin
      mdlIdle++;
      if (mdlIdle == TIMEOUT) begin
        mdlBytes.delete();
        mdlErr  = 1;
        mdlIdle = 0;
      end
    end
`endif
    if (mdlBytes.size() == 0) mdlIdle = 0;
  endtask

  // Single compare process: check DUT against the model, then step the model.
  always @(negedge clk) begin
    if (rst) begin
      resetModel();
      checkVal("rst_in_ready", bus.in_ready, 1);
      checkVal("rst_out_valid", bus.out_valid, 0);
      checkVal("rst_out_block", bus.out_block, 0);
      checkVal("rst_out_round", bus.out_round, 0);
      checkVal("rst_err", bus.err, 0);
    end else begin
      checkVal("in_ready", bus.in_ready, expReady());
      checkVal("out_valid", bus.out_valid, mdlOutValid);
      checkVal("err", bus.err, mdlErr);
      if (mdlOutValid) begin
        checkVal("out_block", bus.out_block, mdlOutBlock);
        checkVal("out_round", bus.out_round, mdlOutRound);
      end
      advanceModel();
    end
  end

  // Drive one cycle of inputs; the byte strobe drops right after the edge.
  task automatic applyStimulus(input bit v, input bit f, input logic [7:0] b, input bit r);
    bus.in_valid  = v;
    bus.in_first  = f;
    bus.in_byte   = b;
    bus.out_ready = r;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
  endtask

  task automatic sendBytes(input logic [127:0] blk, input int first, input int last, input bit r);
    for (int k = first; k <= last; k++) begin
      applyStimulus(1'b1, k == 0, blk[127-8*k -: 8], r);
    end
  endtask

  // Literal checks taken at posedge+1.
  task automatic checkOutput(input string tag, input bit expRdy, input bit expValid,
                             input logic [127:0] expBlock, input round_t expRound,
                             input bit expErr, input bit chkBlock);
    checkVal({tag, "_in_ready"}, bus.in_ready, expRdy);
    checkVal({tag, "_out_valid"}, bus.out_valid, expValid);
    checkVal({tag, "_err"}, bus.err, expErr);
    if (chkBlock) begin
      checkVal({tag, "_out_block"}, bus.out_block, expBlock);
      checkVal({tag, "_out_round"}, bus.out_round, expRound);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [127:0] randBlock();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [127:0] b0, b1, b2, b3, b4, b5, b6, b7;
    bus.in_valid  = 1'b0;
    bus.in_first  = 1'b0;
    bus.in_byte   = 8'h00;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset", 1, 0, '0, 4'd0, 0, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] basic block");
    sendBytes(128'h2b7e151628aed2a6abf7158809cf4f3c, 0, 15, 1);
    checkOutput("basic", 1, 1, 128'h2b7e151628aed2a6abf7158809cf4f3c, 4'd0, 0, 1);
    applyStimulus(0, 0, 8'h00, 1);
    checkOutput("basic_xfer", 1, 0, '0, 4'd0, 0, 0);

    $display("[TB] full schedule plus wrap");
    doReset();
    for (int b = 0; b < 12; b++) begin
      b0 = randBlock();
      sendBytes(b0, 0, 15, 1);
      checkOutput("sched", 1, 1, b0, round_t'(b % NUM_BLOCKS), 0, 1);
    end
    applyStimulus(0, 0, 8'h00, 1);

    $display("[TB] back-pressure");
    doReset();
    b0 = randBlock();
    b1 = randBlock();
    sendBytes(b0, 0, 15, 1);
    bus.out_ready = 1'b0;
    sendBytes(b1, 0, 14, 0);
    checkOutput("stall", 0, 1, b0, 4'd0, 0, 1);
    repeat (3) applyStimulus(0, 0, 8'h00, 0);
    checkOutput("stall_hold", 0, 1, b0, 4'd0, 0, 1);
    applyStimulus(0, 0, 8'h00, 1);
    checkOutput("stall_xfer", 1, 0, '0, 4'd0, 0, 0);
    applyStimulus(1, 0, b1[7:0], 1);
    checkOutput("stall_b1", 1, 1, b1, 4'd1, 0, 1);

    $display("[TB] simultaneous accept and complete");
    b2 = randBlock();
    sendBytes(b2, 0, 14, 0);
    checkOutput("simul_hold", 0, 1, b1, 4'd1, 0, 1);
    applyStimulus(1, 0, b2[7:0], 1);
    checkOutput("simul", 1, 1, b2, 4'd2, 0, 1);
    applyStimulus(0, 0, 8'h00, 1);

    $display("[TB] resync on early in_first");
    b3 = randBlock();
    sendBytes(randBlock(), 0, 6, 1);
    checkOutput("resync_pre", 1, 0, '0, 4'd0, 0, 0);
    sendBytes(b3, 0, 15, 1);
    checkOutput("resync", 1, 1, b3, 4'd3, 1, 1);
    applyStimulus(0, 0, 8'h00, 1);

    $display("[TB] byte while not ready");
    doReset();
    b4 = randBlock();
    b5 = randBlock();
    sendBytes(b4, 0, 15, 1);
    bus.out_ready = 1'b0;
    sendBytes(b5, 0, 14, 0);
    checkOutput("noready_pre", 0, 1, b4, 4'd0, 0, 1);
    applyStimulus(1, 0, ~b5[7:0], 0);
    checkOutput("noready_err", 0, 1, b4, 4'd0, 1, 1);
    applyStimulus(0, 0, 8'h00, 1);
    applyStimulus(1, 0, b5[7:0], 1);
    checkOutput("noready_b5", 1, 1, b5, 4'd1, 1, 1);
    applyStimulus(0, 0, 8'h00, 1);

    doReset();
    b6 = randBlock();
`ifdef STP_KEY_TIMEOUT_EN
    $display("[TB] partial block timeout");
    sendBytes(randBlock(), 0, 4, 1);
    repeat (TIMEOUT - 1) applyStimulus(0, 0, 8'h00, 1);
    checkOutput("timeout_pre", 1, 0, '0, 4'd0, 0, 0);
    applyStimulus(0, 0, 8'h00, 1);
    checkOutput("timeout", 1, 0, '0, 4'd0, 1, 0);
    sendBytes(b6, 0, 15, 1);
    checkOutput("timeout_blk", 1, 1, b6, 4'd0, 1, 1);
`else
    $display("[TB] partial block waits without timeout");
    sendBytes(b6, 0, 4, 1);
    repeat (TIMEOUT + 8) applyStimulus(0, 0, 8'h00, 1);
    sendBytes(b6, 5, 15, 1);
    checkOutput("notimeout_blk", 1, 1, b6, 4'd0, 0, 1);
`endif
    applyStimulus(0, 0, 8'h00, 1);

    $display("[TB] randomized traffic");
    doReset();
    for (int n = 0; n < 2000; n++) begin
      bit v;
      bit f;
      bit r;
      if ($urandom_range(0, 199) == 0) begin
        repeat (TIMEOUT + 4) applyStimulus(0, 0, 8'h00, 1'($urandom_range(0, 1)));
      end
      v = ($urandom_range(0, 3) != 0);
      f = v && ($urandom_range(0, 24) == 0);
      r = ($urandom_range(0, 3) != 0);
      applyStimulus(v, f, 8'($urandom()), r);
    end

    $display("[TB] reset mid-block");
    doReset();
    b7 = randBlock();
    sendBytes(randBlock(), 0, 15, 0);
    sendBytes(randBlock(), 0, 5, 0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst", 1, 0, '0, 4'd0, 0, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sendBytes(b7, 0, 15, 1);
    checkOutput("midrst_blk", 1, 1, b7, 4'd0, 0, 1);
    applyStimulus(0, 0, 8'h00, 1);
    applyStimulus(0, 0, 8'h00, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/stp_key.md
Name: stp_key

Overview:
Serial-to-parallel key/block collector. It is the receive end of the byte-serial round-key stream produced by the key serializer: one byte per clock, most significant byte first, 16 bytes per block, NUM_BLOCKS blocks per key schedule. It reassembles each 128-bit block, tags it with its round index, and hands it downstream with a valid/ready handshake. Back-pressure reaches the byte source through in_ready.

Parameters:
NUM_BLOCKS, 11, blocks per schedule; sets the out_round wrap point (valid range 1..16).
TIMEOUT, 32, idle cycles before a partial block is discarded (used only when STP_KEY_TIMEOUT_EN is defined).

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  in_byte valid this cycle
in_byte  input  8  serial byte; first byte of a block maps to bits [127:120]
in_first  input  1  marks in_byte as byte 0 of a block; qualified by in_valid
in_ready  output  1  collector can accept a byte this cycle
out_valid  output  1  out_block/out_round hold a complete block
out_ready  input  1  downstream accepts the block
out_block  output  128  assembled block
out_round  output  4  round index of out_block, 0..NUM_BLOCKS-1
err  output  1  sticky error flag; cleared only by rst

Behaviour:
- Reset values: all outputs 0 except in_ready=1. byte_cnt=0, round counter=0, collect register=0.
- Accepted byte: in_valid && in_ready at a rising edge. Byte k (0..15) is written to collect[127-8k -: 8], then byte_cnt increments.
- in_first on an accepted byte:
  - Always writes to slot 0 and sets byte_cnt=1.
  - If byte_cnt was not 0, the partial block is dropped and err is set.
- Block completion: accepted byte with byte_cnt=15.
  - Completed value (collect with the final byte merged) loads into out_block in the same edge.
  - out_round is loaded with the round counter; out_valid=1 from the next cycle.
  - Latency: last byte to out_valid is 1 cycle. byte_cnt wraps to 0.
  - Round counter increments and wraps NUM_BLOCKS-1 -> 0.
- Output hold: while out_valid && !out_ready, out_block and out_round stay stable.
- Transfer: out_valid && out_ready at an edge clears out_valid, unless a new block completes in the same edge. In that case out_valid stays 1 and the new block/round load, giving back-to-back throughput with no bubble.
- in_ready = !(byte_cnt==15 && out_valid && !out_ready). Bytes 0..14 of the next block are always accepted while the output is held.
- in_valid while !in_ready: byte ignored, no state change, err set.
- No FSM beyond byte_cnt. States by count: EMPTY (0), FILLING (1..15), STALLED (15 with in_ready=0).
- Mid-operation rst: asynchronous clear of all of the above; partial block and pending output are lost.
- in_byte is don't-care when in_valid=0.

Optional Feature:
Macro STP_KEY_TIMEOUT_EN.
- Defined:
  - An idle counter runs while byte_cnt!=0 and no byte is accepted, and clears on every accepted byte.
  - Reaching TIMEOUT consecutive idle cycles sets byte_cnt=0, discards the partial block and sets err. The round counter is unchanged.
  - Idle time does not count while in_ready=0.
- Undefined: no idle counter; a partial block waits indefinitely.

Decomposition:
- Package stp_key_pkg:
  - BLOCK_BYTES=16, BYTE_W=8, BLOCK_W=128.
  - Round-index width localparam (4).
  - Function byte_slot(k) returning the MSB bit position 127-8k.
- One natural sub-module: stp_key_outreg, the 128+4-bit output holding register with the valid/ready handshake (load, hold, simultaneous load-and-accept).
- Byte counter, round counter and timeout logic stay in the top.

Test Plan:
- Basic block: stream bytes 2b 7e 15 16 28 ae d2 a6 ab f7 15 88 09 cf 4f 3c (in_first on 2b), out_ready=1 -> out_valid one cycle after byte 3c, out_block=128'h2b7e151628aed2a6abf7158809cf4f3c, out_round=0, err=0.
- Full schedule: 11 back-to-back blocks, 176 consecutive bytes, out_ready=1 -> 11 out_valid pulses, out_round 0..10, then the 12th block gives out_round=0; no gaps; in_ready constantly 1.
- Back-pressure: out_ready=0 after block 0, send next 16 bytes -> bytes 0..14 accepted; in_ready=0 while byte 15 is held; out_block unchanged. Raise out_ready -> block 0 transfers; the following edge accepts byte 15; block 1 appears next cycle with round 1.
- Simultaneous accept/complete: out_valid=1 with out_ready=1 in the same edge as byte 15 of the next block -> out_valid stays 1, out_block updates, no lost block.
- Resync and error: in_first asserted at byte 7 of a block -> err=1; the following 16 bytes form the block correctly. A byte driven while in_ready=0 -> err=1 and the byte is ignored.
- Timeout (STP_KEY_TIMEOUT_EN, TIMEOUT=32): 5 bytes then 32 idle cycles -> err=1, byte_cnt=0; the next full 16-byte block assembles correctly. Assert rst mid-block -> all outputs 0, in_ready=1.
